// File: rtl/apu_pkg.sv
// Shared widths and sample conversion for the APU audio output path.
package apu_pkg;

  localparam int SAMPLE_W     = 9;
  localparam int PCM_W        = 16;
  localparam int SLOT_BITS    = 16;
  localparam int FRAME_BITS   = 32;
  localparam int MIDPOINT_DEF = 256;

  // Re-centre the unsigned mixer code on zero and left-justify it into a PCM word.
  function automatic logic signed [PCM_W-1:0] to_pcm(input logic [SAMPLE_W-1:0] x,
                                                     input int midpoint);
    int d;
    d = int'(x) - midpoint;
    return PCM_W'(d * 128);
  endfunction

endpackage

// File: rtl/bclk_divider.sv
// Bit-clock generator: divides clk down to BCLK and flags the clk edge on which BCLK falls.
module bclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic i2s_bclk,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          at_top;

  assign at_top    = (div_cnt == CW'(CLK_DIV - 1));
  assign fall_tick = enable && at_top && i2s_bclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (!enable) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (at_top) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/apu_i2s_tx.sv
// Philips I2S transmitter for the APU mixer: converts the L/R pair to 16-bit PCM and serialises it.
module apu_i2s_tx
  import apu_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int MIDPOINT = MIDPOINT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                mute,
  input  logic [SAMPLE_W-1:0] sound_l,
  input  logic [SAMPLE_W-1:0] sound_r,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata,
  output logic                frame_strobe
);

  localparam int NW = $clog2(FRAME_BITS);

  logic                  fall_tick;
  logic [NW-1:0]         n;
  logic [NW-1:0]         n_next;
  logic [FRAME_BITS-1:0] sh;
  logic [FRAME_BITS-1:0] frame_word;
  logic [PCM_W-1:0]      pcm_l;
  logic [PCM_W-1:0]      pcm_r;

  bclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .i2s_bclk  (i2s_bclk),
    .fall_tick (fall_tick)
  );

  always_comb begin
    pcm_l      = mute ? '0 : to_pcm(sound_l, MIDPOINT);
    pcm_r      = mute ? '0 : to_pcm(sound_r, MIDPOINT);
    frame_word = {pcm_l, pcm_r};
    n_next     = n + NW'(1);
  end

  // The old sh[31] goes out on the load tick too, which gives the one-BCLK I2S delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n            <= '1;
      sh           <= '0;
      i2s_lrck     <= 1'b0;
      i2s_sdata    <= 1'b0;
      frame_strobe <= 1'b0;
    end else if (!enable) begin
      n            <= '1;
      sh           <= '0;
      i2s_lrck     <= 1'b0;
      i2s_sdata    <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (fall_tick) begin
        n         <= n_next;
        i2s_lrck  <= n_next[NW-1];
        i2s_sdata <= sh[FRAME_BITS-1];
        if (n_next == '0) begin
          sh           <= frame_word;
          frame_strobe <= 1'b1;
        end else begin
          sh <= sh << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_i2s_tx.sv
// Randomised bench for apu_i2s_tx: two instances (CLK_DIV=2 and 1) against a slot-position model.
module tb_apu_i2s_tx;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       mute;
  logic [8:0] sound_l;
  logic [8:0] sound_r;

  logic bclk_o [2];
  logic lrck_o [2];
  logic sd_o   [2];
  logic fs_o   [2];

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference PCM word: offset from mid-scale, scaled by 128, kept to 16 bits.
  function automatic logic [15:0] ref_pcm(input logic [8:0] x, input logic m);
    int v;
    v = (int'(x) - 256) * 128;
    return m ? 16'h0000 : v[15:0];
  endfunction

  // Bit on the line after the tick into position p: left slot p=1..16, right p=17..31, right LSB at p=0.
  function automatic logic ref_bit(input int p, input logic [15:0] wl, input logic [15:0] wr_cur,
                                   input logic [15:0] wr_prev);
    if (p == 0)       return wr_prev[0];
    else if (p <= 16) return wl[16 - p];
    else              return wr_cur[32 - p];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int D = (g == 0) ? 2 : 1;

    apu_i2s_tx #(.CLK_DIV(D), .MIDPOINT(256)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .mute         (mute),
      .sound_l      (sound_l),
      .sound_r      (sound_r),
      .i2s_bclk     (bclk_o[g]),
      .i2s_lrck     (lrck_o[g]),
      .i2s_sdata    (sd_o[g]),
      .frame_strobe (fs_o[g])
    );

    int          m_c;
    int          m_n;
    int          nn;
    logic        tick;
    logic [15:0] m_wl, m_wr, new_wl, new_wr;
    logic        e_bclk, e_lrck, e_sd, e_fs;

    assign nn     = (m_n + 1) % 32;
    assign tick   = ((m_c + 1) % (2 * D)) == 0;
    assign new_wl = ref_pcm(sound_l, mute);
    assign new_wr = ref_pcm(sound_r, mute);

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n || !enable) begin
        m_c    <= 0;
        m_n    <= 31;
        m_wl   <= '0;
        m_wr   <= '0;
        e_bclk <= 1'b0;
        e_lrck <= 1'b0;
        e_sd   <= 1'b0;
        e_fs   <= 1'b0;
      end else begin
        m_c    <= (m_c + 1) % (2 * D);
        e_bclk <= (((m_c + 1) / D) % 2) == 1;
        e_fs   <= tick && (nn == 0);
        if (tick) begin
          m_n    <= nn;
          e_lrck <= (nn >= 16);
          e_sd   <= (nn == 0) ? ref_bit(0, m_wl, m_wr, m_wr)
                              : ref_bit(nn, m_wl, m_wr, m_wr);
          if (nn == 0) begin
            m_wl <= new_wl;
            m_wr <= new_wr;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (checking) begin
        chk($sformatf("d%0d_bclk", D),  32'(bclk_o[g]), 32'(e_bclk));
        chk($sformatf("d%0d_lrck", D),  32'(lrck_o[g]), 32'(e_lrck));
        chk($sformatf("d%0d_sdata", D), 32'(sd_o[g]),   32'(e_sd));
        chk($sformatf("d%0d_strobe", D), 32'(fs_o[g]),  32'(e_fs));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset pulse placed between clk edges; outputs must clear before the next edge.
  task automatic async_reset_pulse();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_bclk",  32'(bclk_o[i]), 32'd0);
      chk("async_rst_lrck",  32'(lrck_o[i]), 32'd0);
      chk("async_rst_sdata", 32'(sd_o[i]),   32'd0);
      chk("async_rst_strobe", 32'(fs_o[i]),  32'd0);
    end
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mute    = 1'b0;
    sound_l = 9'd256;
    sound_r = 9'd256;
    wait_clks(2);
    checking = 1'b1;
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(3);
    enable = 1'b1;
    wait_clks(300);

    sound_l = 9'h1FF;
    sound_r = 9'h000;
    wait_clks(260);

    sound_l = 9'd300;
    sound_r = 9'd300;
    wait_clks(150);
    sound_l = 9'd100;
    wait_clks(300);

    sound_l = 9'd400;
    sound_r = 9'd400;
    wait_clks(140);
    mute = 1'b1;
    wait_clks(150);
    mute = 1'b0;
    wait_clks(300);

    wait_clks(41);
    enable = 1'b0;
    wait_clks(50);
    enable = 1'b1;
    wait_clks(200);

    async_reset_pulse();
    wait_clks(200);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          sound_l = 9'($urandom_range(0, 511));
          sound_r = 9'($urandom_range(0, 511));
        end
        2: mute = 1'($urandom_range(0, 1));
        3: begin
          enable = 1'b0;
          wait_clks($urandom_range(1, 40));
          enable = 1'b1;
        end
        default: async_reset_pulse();
      endcase
      wait_clks($urandom_range(1, 150));
    end

    wait_clks(10);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apu_i2s_tx.md
Name: apu_i2s_tx

Overview:
- Transmitter end of the APU sample interface: takes the registered 9-bit unsigned mixer outputs (sound_l, sound_r) and serialises them to an external audio DAC as standard Philips I2S.
- Sits beside the APU top level: the APU is the sample producer and this block is the consumer/driver.
- Converts samples to 16-bit two's complement and generates BCLK, LRCK and SDATA from the system clock.

Parameters:
- CLK_DIV, 4, clk cycles per BCLK half-period (>=1); BCLK = clk / (2*CLK_DIV).
- MIDPOINT, 256, unsigned mixer code that maps to PCM zero.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  run serialiser; low = idle
- mute  input  1  force both PCM words to 0x0000 at next load
- sound_l  input  9  unsigned left sample from APU
- sound_r  input  9  unsigned right sample from APU
- i2s_bclk  output  1  bit clock
- i2s_lrck  output  1  word select, 0 = left, 1 = right
- i2s_sdata  output  1  serial data, MSB first
- frame_strobe  output  1  one-clk pulse when a new L/R pair is latched

Behaviour:
- Reset (async, reset_n=0) values: i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, frame_strobe=0, div_cnt=0, bit counter n=31, shift register=0.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1. At CLK_DIV-1, i2s_bclk toggles and div_cnt returns to 0.
- Every event below happens on the clk edge where i2s_bclk goes 1->0 (the "falling tick"). All outputs are registered.
- Bit counter: n advances modulo 32 on each falling tick. A frame is 32 BCLKs, 16-bit slots.
- LRCK: i2s_lrck <= 0 when the new n is 0..15, and 1 when it is 16..31.
- Shift register: sh is 32 bits.
  - Tick into n=0: i2s_sdata <= sh[31] (previous right LSB); sh <= {pcm(sound_l), pcm(sound_r)} sampled that same clk; frame_strobe=1 for exactly that clk.
  - Tick into n=1..31: i2s_sdata <= sh[31]; sh <= sh << 1.
- Result: left MSB appears one BCLK after the LRCK falling edge, right MSB one BCLK after the LRCK rising edge (I2S 1-bit delay).
- Sampling is atomic: L and R are captured in the same clk, so there is no L/R tearing. The inputs are not sampled at any other time.
- PCM conversion: pcm(x) = (x - MIDPOINT) sign-extended to 16 bits, then shifted left 7; the 7 LSBs are zero.
  - Examples: 256 -> 0x0000; 0 -> 0x8000; 511 -> 0x7F80; 257 -> 0x0080.
  - No saturation is needed for MIDPOINT=256.
- mute=1 sampled at the load tick forces both words to 0x0000. Mute changes mid-frame take effect at the next frame.
- enable=0: synchronously returns div_cnt=0, i2s_bclk=0, i2s_lrck=0, i2s_sdata=0 and n=31, and holds them there. The partial frame is discarded.
  - On re-enable, the first falling tick (after 2*CLK_DIV clks) loads a fresh frame at n=0.
- reset_n asserted mid-frame: all state returns immediately to the reset values. Same restart rule as re-enable.
- CLK_DIV=1: BCLK = clk/2. Exactly one falling tick every 2 clks; all rules above still hold.

Decomposition:
- apu_pkg holds:
  - SAMPLE_W=9 and PCM_W=16
  - SLOT_BITS=16 and FRAME_BITS=32
  - the MIDPOINT default
  - function to_pcm (9-bit unsigned -> 16-bit signed)
- One sub-module, bclk_divider: div_cnt and BCLK toggle, with outputs i2s_bclk and fall_tick.
- Framing, LRCK and shift logic stay in apu_i2s_tx.

Test Plan:
- Reset then enable=1, CLK_DIV=2, sound_l=256, sound_r=256 -> BCLK period 4 clk; LRCK period 128 clk with 64 clk low; SDATA all 0; frame_strobe once per 128 clk.
- sound_l=0x1FF, sound_r=0x000 -> left slot bits n=1..16 = 0x7F80 MSB first; right slot n=17..31 then next n=0 = 0x8000; LRCK edges one BCLK before each MSB.
- Change sound_l from 300 to 100 mid-frame (n=8) -> current frame unchanged (0x1600); next frame carries 0xB200; frame_strobe coincides with the load.
- mute=1 from n=5 with sound_l=sound_r=400 -> current frame still 0x4800/0x4800; next frame 0x0000/0x0000; mute=0 restores 0x4800 one frame later.
- Drop enable at n=20, raise it 50 clk later -> outputs low while disabled; first falling tick after re-enable occurs 2*CLK_DIV clk later and is a load (frame_strobe, left MSB at the next tick).
- CLK_DIV=1, and async reset_n pulse mid-bit (between clk edges) -> outputs clear immediately without waiting for clk; bit stream restarts cleanly with correct 32-BCLK framing.
